// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives the word-indexed imem
// address and fills the IF/ID register, with stall, redirect and fault.
module fetch_stage #(
    parameter int addr_ins_width = 32,
    parameter int memory_height = 512,
    parameter logic [addr_ins_width-1:0] RESET_PC = '0,
    parameter logic [addr_ins_width-1:0] NOP_INSTR = 'h13
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      stall_i,
    input  logic                      redirect_i,
    input  logic [addr_ins_width-1:0] redirect_target_i,
    output logic [addr_ins_width-1:0] imem_addr_o,
    input  logic [addr_ins_width-1:0] imem_instr_i,
    output logic [addr_ins_width-1:0] pc_o,
    output logic [addr_ins_width-1:0] id_pc_o,
    output logic [addr_ins_width-1:0] id_instr_o,
    output logic                      id_valid_o,
    output logic                      fault_o,
    output logic [addr_ins_width-1:0] fault_pc_o,
    output logic [addr_ins_width-1:0] fetch_count_o
);

    localparam int W = addr_ins_width;
    localparam logic [W-1:0] PC_LIMIT = W'(4 * memory_height);

    typedef enum logic {RUN, FAULT} state_t;

    typedef struct packed {
        logic [W-1:0] pc;
        logic [W-1:0] instr;
        logic         valid;
    } if_id_t;

    localparam if_id_t BUBBLE = '{pc: '0, instr: NOP_INSTR, valid: 1'b0};

    state_t       state_q, state_d;
    logic [W-1:0] pc_q, pc_d;
    if_id_t       ifid_q, ifid_d;
    logic [W-1:0] count_q, count_d;
    logic [W-1:0] fault_pc_q, fault_pc_d;
    logic [W-1:0] pc_plus4;
    logic         target_ok;
    logic         seq_ok;
    logic         do_redirect;
    logic         do_stall;
    logic         do_advance;

    function automatic logic legal(input logic [W-1:0] a);
        return (a[1:0] == 2'b00) && (a < PC_LIMIT);
    endfunction

    assign pc_plus4    = pc_q + W'(4);
    assign target_ok   = legal(redirect_target_i);
    assign seq_ok      = legal(pc_plus4);
    assign do_redirect = redirect_i;
    assign do_stall    = stall_i && !redirect_i;
    assign do_advance  = !stall_i && !redirect_i;

    // State register and all datapath registers, synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= RUN;
            pc_q       <= RESET_PC;
            ifid_q     <= BUBBLE;
            count_q    <= '0;
            fault_pc_q <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            ifid_q     <= ifid_d;
            count_q    <= count_d;
            fault_pc_q <= fault_pc_d;
        end
    end

    // Next state: an illegal redirect or sequential PC traps into FAULT
    always_comb begin
        state_d = state_q;
        if (state_q == RUN) begin
            if (do_redirect && !target_ok)
                state_d = FAULT;
            else if (do_advance && !seq_ok)
                state_d = FAULT;
        end
    end

    // Next datapath values: redirect beats stall beats advance
    always_comb begin
        pc_d       = pc_q;
        ifid_d     = ifid_q;
        count_d    = count_q;
        fault_pc_d = fault_pc_q;
        if (state_q == FAULT) begin
            ifid_d = BUBBLE;
        end else begin
            unique case (1'b1)
                do_redirect: begin
                    ifid_d = BUBBLE;
                    if (target_ok)
                        pc_d = redirect_target_i;
                    else
                        fault_pc_d = redirect_target_i;
                end
                do_stall: begin
                end
                do_advance: begin
                    ifid_d  = '{pc: pc_q, instr: imem_instr_i, valid: 1'b1};
                    count_d = count_q + W'(1);
                    if (seq_ok)
                        pc_d = pc_plus4;
                    else
                        fault_pc_d = pc_plus4;
                end
            endcase
        end
    end

    assign imem_addr_o   = pc_q >> 2;
    assign pc_o          = pc_q;
    assign id_pc_o       = ifid_q.pc;
    assign id_instr_o    = ifid_q.instr;
    assign id_valid_o    = ifid_q.valid;
    assign fault_o       = (state_q == FAULT);
    assign fault_pc_o    = fault_pc_q;
    assign fetch_count_o = count_q;

endmodule
